// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks a target TAP through reset, IR and DR scans one command
// at a time, shifting TDI LSB-first and returning the captured TDO bits.
module jtag_tap_driver #(
  parameter int MaxLen = 32,
  parameter int ClkDiv = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_tlr_i,
  input  logic                    req_ir_i,
  input  logic [$clog2(MaxLen):0] req_len_i,
  input  logic [MaxLen-1:0]       req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [MaxLen-1:0]       rsp_data_o,
  output logic                    jtag_tck_o,
  output logic                    jtag_tms_o,
  output logic                    jtag_tdi_o,
  output logic                    jtag_trst_no,
  input  logic                    jtag_tdo_i
);

  localparam int LW  = $clog2(MaxLen) + 1;
  localparam int IW  = (LW > 3) ? LW : 3;
  localparam int IXW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int CW  = $clog2(2 * ClkDiv + 1);
  localparam logic [CW-1:0] RiseCnt = CW'(ClkDiv - 1);
  localparam logic [CW-1:0] EndCnt  = CW'(2 * ClkDiv - 1);
  localparam logic [LW-1:0] MaxLenL = LW'(MaxLen);

  typedef enum logic [2:0] {
    S_TLR, S_IDLE, S_SEL, S_SHIFT, S_EXIT, S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic              trst_n_q;
  logic              tlr_req_q, tlr_req_d, ir_q, ir_d;
  logic [LW-1:0]     len_q, len_d;
  logic [MaxLen-1:0] data_q, data_d, cap_q, cap_d;

  logic          ticking, tick_end;
  logic [IW-1:0] idx_nxt, last_bit;

  // Ticks only run once TRSTn has been released, so the boot TLR walk starts
  // one cycle after reset deassertion.
  assign ticking  = trst_n_q && (state_q == S_TLR || state_q == S_SEL ||
                                 state_q == S_SHIFT || state_q == S_EXIT);
  assign tick_end = ticking && (cnt_q == EndCnt);
  assign idx_nxt  = idx_q + IW'(1);
  assign last_bit = IW'(len_q) - IW'(1);

  // Handshakes: a transfer happens on a clk_i edge where valid and ready are
  // both high; valid holds its payload stable until then and ready never
  // depends on valid (req_ready_o only in IDLE, rsp_valid_o only in RSP).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    tlr_req_d = tlr_req_q;
    ir_d      = ir_q;
    len_d     = len_q;
    data_d    = data_q;
    cap_d     = cap_q;

    if (ticking) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == RiseCnt) begin
        tck_d = 1'b1;
        if (state_q == S_SHIFT) cap_d[idx_q[IXW-1:0]] = jtag_tdo_i;
      end
      if (tick_end) begin
        cnt_d = '0;
        tck_d = 1'b0;
        idx_d = idx_nxt;
      end
    end

    // On each tick end, TMS/TDI are loaded for the tick that starts now.
    case (state_q)
      S_TLR: begin
        if (tick_end) begin
          tms_d = (idx_q < IW'(4));
          if (idx_q == IW'(5)) begin
            idx_d   = '0;
            tms_d   = 1'b1;
            state_d = tlr_req_q ? S_RSP : S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (req_valid_i) begin
          tlr_req_d = req_tlr_i;
          ir_d      = req_ir_i;
          len_d     = (req_len_i > MaxLenL) ? MaxLenL : req_len_i;
          data_d    = req_data_i;
          cap_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          tck_d     = 1'b0;
          tms_d     = 1'b1;
          tdi_d     = 1'b0;
          if (req_tlr_i)              state_d = S_TLR;
          else if (req_len_i == '0)   state_d = S_RSP;
          else                        state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (tick_end) begin
          tms_d = ir_q && (idx_q == '0);
          if (idx_q == (ir_q ? IW'(3) : IW'(2))) begin
            idx_d   = '0;
            tdi_d   = data_q[0];
            tms_d   = (len_q == LW'(1));
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (tick_end) begin
          tdi_d = data_q[idx_nxt[IXW-1:0]];
          tms_d = (idx_nxt == last_bit);
          if (idx_q == last_bit) begin
            idx_d   = '0;
            tdi_d   = 1'b0;
            tms_d   = 1'b1;
            state_d = S_EXIT;
          end
        end
      end
      S_EXIT: begin
        if (tick_end) begin
          tms_d = 1'b0;
          if (idx_q == IW'(1)) begin
            idx_d   = '0;
            tms_d   = 1'b1;
            state_d = S_RSP;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_TLR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_TLR;
      cnt_q     <= '0;
      idx_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      trst_n_q  <= 1'b0;
      tlr_req_q <= 1'b0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      trst_n_q  <= 1'b1;
      tlr_req_q <= tlr_req_d;
      ir_q      <= ir_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_RSP);
  assign rsp_data_o   = cap_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_n_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: an IEEE 1149.1 target TAP model on the pins plus
// directed vectors, hand-written corner sequences and random commands.
module tb_jtag_tap_driver;
  localparam int MaxLen = 32;
  localparam int ClkDiv = 2;
  localparam int LW     = $clog2(MaxLen) + 1;

  logic              clk, rst;
  logic              req_valid, req_ready, req_tlr, req_ir;
  logic [LW-1:0]     req_len;
  logic [MaxLen-1:0] req_data;
  logic              rsp_valid, rsp_ready;
  logic [MaxLen-1:0] rsp_data;
  logic              tck, tms, tdi, trst_n, tdo;

  int total = 0;
  int bad   = 0;

  jtag_tap_driver #(.MaxLen(MaxLen), .ClkDiv(ClkDiv)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_tlr_i(req_tlr), .req_ir_i(req_ir), .req_len_i(req_len), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
    .jtag_trst_no(trst_n), .jtag_tdo_i(tdo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- target TAP model ----------------
  typedef enum int {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_e;

  tap_e        tap = T_TLR;
  logic [31:0] dr_reg = '0, dr_sr = '0;
  int          dr_len = 32;
  logic [4:0]  ir_reg = '0, ir_sr = '0;
  int          ticks = 0;
  logic [63:0] tms_log = '0;
  int          tdi_viol = 0;
  logic        tck_prev = 1'b0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  initial tdo = 1'b0;

  // Pins are observed mid-cycle; every TCK level lasts at least one clk period.
  always @(negedge clk) begin
    if (!trst_n) begin
      tap = T_TLR;
    end else if (tck && !tck_prev) begin
      if (tdi !== 1'b0 && tap != T_SHDR && tap != T_SHIR) tdi_viol++;
      if (ticks < 64) tms_log = tms_log | (64'(tms) << ticks);
      ticks++;
      case (tap)
        T_CDR:  dr_sr = dr_reg;
        T_SHDR: dr_sr = (dr_sr >> 1) | (32'(tdi) << (dr_len - 1));
        T_UDR:  dr_reg = dr_sr;
        T_CIR:  ir_sr = 5'b00001;
        T_SHIR: ir_sr = {tdi, ir_sr[4:1]};
        T_UIR:  ir_reg = ir_sr;
        default: ;
      endcase
      tap = tap_next(tap, tms);
    end else if (!tck && tck_prev) begin
      tdo = (tap == T_SHDR) ? dr_sr[0] : (tap == T_SHIR) ? ir_sr[0] : 1'b0;
    end
    tck_prev = tck;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] mask64(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Bit stream through a register of length l holding c: first l bits out are
  // c, followed by the shifted-in data; the last l bits remain in the register.
  function automatic void shift_model(input logic [31:0] c, input int l, input logic [31:0] d,
                                      input int n, output logic [31:0] out, output logic [31:0] nreg);
    logic [63:0] s;
    s    = (64'(c) & mask64(l)) | ((64'(d) & mask64(n)) << l);
    out  = 32'(s & mask64(n));
    nreg = 32'((s >> n) & mask64(l));
  endfunction

  function automatic logic [63:0] tms_model(input logic t, input logic i, input int n);
    logic [63:0] s;
    int k;
    s = '0;
    if (t) begin
      s = 64'h1F;
    end else if (n > 0) begin
      s = 64'd1;
      k = 1;
      if (i) begin
        s = s | 64'd2;
        k = 2;
      end
      k = k + 2 + n - 1;
      s = s | (64'd1 << k);
      s = s | (64'd1 << (k + 1));
    end
    return s;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic send(input logic t, input logic i, input int len, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout_fail("req_ready_wait");
    ticks = 0; tms_log = '0; tdi_viol = 0;
    req_valid = 1'b1; req_tlr = t; req_ir = i; req_len = LW'(len); req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int delay, output logic [31:0] d, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) timeout_fail("rsp_wait");
    d = rsp_data;
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        tlr;
    logic        ir;
    int          len;
    logic [31:0] data;
    int          dr_len;
    logic [31:0] dr_pre;
    int          exp_ticks;
    logic [31:0] exp_rsp;
    logic [31:0] exp_tgt;
  } vec_t;

  task automatic run_cmd(input vec_t v, input int delay);
    logic [31:0] d;
    int lat, n;
    n = (v.len > MaxLen) ? MaxLen : v.len;
    dr_len = v.dr_len;
    dr_reg = v.dr_pre;
    send(v.tlr, v.ir, v.len, v.data);
    get_rsp(delay, d, lat);
    check("ticks", 64'(ticks), 64'(v.exp_ticks));
    check("latency", 64'(lat), 64'(2 * ClkDiv * v.exp_ticks));
    check("tms_seq", tms_log, tms_model(v.tlr, v.ir, n));
    check("rsp_data", 64'(d), 64'(v.exp_rsp));
    check("tap_end_state", 64'(tap), 64'(T_RTI));
    check("tdi_outside_shift", 64'(tdi_viol), 64'd0);
    if (!v.tlr) check("target_reg", v.ir ? 64'(ir_reg) : 64'(dr_reg), 64'(v.exp_tgt));
  endtask

  // Called at a negedge with rst high; releases it and checks the boot TLR walk.
  task automatic check_boot(input string tag);
    int cyc;
    logic saw_rsp;
    ticks = 0; tms_log = '0; tdi_viol = 0;
    rst = 1'b0;
    #1;
    check({tag, "_trst_low_at_release"}, 64'(trst_n), 64'd0);
    @(negedge clk);
    check({tag, "_trst_high"}, 64'(trst_n), 64'd1);
    cyc = 1;
    saw_rsp = rsp_valid;
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    if (!req_ready) timeout_fail({tag, "_ready_wait"});
    check({tag, "_ready_cycles"}, 64'(cyc), 64'(25));
    check({tag, "_no_rsp"}, 64'(saw_rsp), 64'd0);
    check({tag, "_ticks"}, 64'(ticks), 64'd6);
    check({tag, "_tms_seq"}, tms_log, 64'h1F);
    check({tag, "_tap_state"}, 64'(tap), 64'(T_RTI));
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    logic [31:0] held, d, e_rsp, e_tgt;
    int lat, stable_err, tick_before, n;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0,  8, 32'h0000_00A5,  8, 32'h0000_003C, 13, 32'h0000_003C, 32'h0000_00A5};
    vecs[1] = '{1'b0, 1'b1,  5, 32'h0000_0001,  8, 32'h0000_0000, 11, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{1'b0, 1'b0,  0, 32'hFFFF_FFFF, 32, 32'h1234_5678,  0, 32'h0000_0000, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 40, 32'hDEAD_BEEF, 32, 32'h0F0F_0F0F, 37, 32'h0F0F_0F0F, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1,  8, 32'h0000_00FF, 32, 32'h0000_0000,  6, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b0, 1'b0,  1, 32'h0000_0001, 32, 32'h8000_0000,  6, 32'h0000_0000, 32'hC000_0000};
    vecs[6] = '{1'b0, 1'b1,  3, 32'h0000_0006, 32, 32'h0000_0000,  9, 32'h0000_0001, 32'h0000_0018};
    vecs[7] = '{1'b0, 1'b0, 32, 32'h1357_9BDF, 32, 32'hFFFF_FFFF, 37, 32'hFFFF_FFFF, 32'h1357_9BDF};

    rst = 1'b1; req_valid = 1'b0; req_tlr = 1'b0; req_ir = 1'b0; req_len = '0; req_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_trst", 64'(trst_n), 64'd0);
    check_boot("boot");

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], i % 3);

    // response back-pressure with a new request already waiting
    dr_len = 32;
    dr_reg = 32'h0BAD_F00D;
    send(1'b0, 1'b0, 8, 32'h0000_005A);
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) timeout_fail("bp_rsp_wait");
    held = rsp_data;
    check("bp_data", 64'(held), 64'h0D);
    req_valid = 1'b1; req_tlr = 1'b0; req_ir = 1'b0; req_len = LW'(12); req_data = 32'h9;
    stable_err = 0;
    tick_before = ticks;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held || req_ready || tck) stable_err++;
    end
    check("bp_stable", 64'(stable_err), 64'd0);
    check("bp_no_tck", 64'(ticks), 64'(tick_before));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after_hs", 64'(req_ready), 64'd1);
    check("bp_valid_after_hs", 64'(rsp_valid), 64'd0);
    ticks = 0; tms_log = '0; tdi_viol = 0;
    @(negedge clk);
    check("bp_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    get_rsp(0, d, lat);
    shift_model(32'h5A0B_ADF0, 32, 32'h9, 12, e_rsp, e_tgt);
    check("bp2_rsp", 64'(d), 64'(e_rsp));
    check("bp2_target", 64'(dr_reg), 64'(e_tgt));
    check("bp2_ticks", 64'(ticks), 64'd17);

    // random commands against the reference model
    for (int k = 0; k < 24; k++) begin
      v.tlr    = ($urandom_range(0, 7) == 0);
      v.ir     = $urandom_range(0, 1);
      v.len    = $urandom_range(0, 40);
      v.data   = $urandom;
      v.dr_len = 32;
      v.dr_pre = $urandom;
      n = (v.len > MaxLen) ? MaxLen : v.len;
      if (v.tlr) begin
        v.exp_ticks = 6; v.exp_rsp = '0; v.exp_tgt = '0;
      end else if (n == 0) begin
        v.exp_ticks = 0; v.exp_rsp = '0;
        v.exp_tgt = v.ir ? 32'(ir_reg) : v.dr_pre;
      end else begin
        v.exp_ticks = n + (v.ir ? 6 : 5);
        if (v.ir) shift_model(32'h1, 5, v.data, n, v.exp_rsp, v.exp_tgt);
        else      shift_model(v.dr_pre, 32, v.data, n, v.exp_rsp, v.exp_tgt);
      end
      run_cmd(v, $urandom_range(0, 3));
    end

    // reset in the middle of shifting bit 3 of an 8-bit DR scan
    dr_len = 32;
    send(1'b0, 1'b0, 8, 32'h0000_00FF);
    lat = 0;
    while (ticks < 7 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (ticks < 7) timeout_fail("mid_shift_wait");
    check("mid_tap_shift", 64'(tap), 64'(T_SHDR));
    check("mid_tck_high", 64'(tck), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tck", 64'(tck), 64'd0);
    check("mid_rst_tms", 64'(tms), 64'd1);
    check("mid_rst_tdi", 64'(tdi), 64'd0);
    check("mid_rst_trst", 64'(trst_n), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_boot("reboot");
    run_cmd(vecs[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
